// File: rtl/nrzi_eop_encoder.sv
// USB full-speed transmit line encoder: NRZI-encodes the stuffed bitstream onto
// dp/dm and closes each packet with SE0, SE0, J, reporting type, length and violations.
module nrzi_eop_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       bstr_in,
    input  logic [1:0] bstr_in_ready,
    output logic       dp,
    output logic       dm,
    output logic       busy,
    output logic       eop_done,
    output logic [1:0] pkt_type,
    output logic [6:0] bit_count,
    output logic       protocol_err
);

    typedef enum logic [2:0] {
        IDLE,
        XMIT,
        SE0_1,
        SE0_2,
        EOP_J
    } state_t;

    state_t state;
    logic   lvl;
    logic   bit_valid;
    logic   enc_lvl;

    assign bit_valid = (bstr_in_ready != 2'b00);
    // A zero toggles the line, a one holds it.
    assign enc_lvl   = bstr_in ? lvl : ~lvl;
    assign busy      = (state != IDLE);

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together on the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lvl          <= 1'b1;
            dp           <= 1'b1;
            dm           <= 1'b0;
            eop_done     <= 1'b0;
            pkt_type     <= 2'b00;
            bit_count    <= 7'd0;
            protocol_err <= 1'b0;
        end else begin
            eop_done     <= 1'b0;
            protocol_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        // lvl is always J here, so the first bit is encoded relative to J.
                        state     <= XMIT;
                        lvl       <= enc_lvl;
                        dp        <= enc_lvl;
                        dm        <= ~enc_lvl;
                        pkt_type  <= bstr_in_ready;
                        bit_count <= 7'd1;
                    end else begin
                        dp <= 1'b1;
                        dm <= 1'b0;
                    end
                end
                XMIT: begin
                    if (bit_valid) begin
                        lvl <= enc_lvl;
                        dp  <= enc_lvl;
                        dm  <= ~enc_lvl;
                        if (bit_count != 7'd127) begin
                            bit_count <= bit_count + 7'd1;
                        end
                        if (bstr_in_ready != pkt_type) begin
                            protocol_err <= 1'b1;
                        end
                    end else begin
                        state <= SE0_1;
                        dp    <= 1'b0;
                        dm    <= 1'b0;
                    end
                end
                SE0_1: begin
                    state        <= SE0_2;
                    dp           <= 1'b0;
                    dm           <= 1'b0;
                    protocol_err <= bit_valid;
                end
                SE0_2: begin
                    state        <= EOP_J;
                    lvl          <= 1'b1;
                    dp           <= 1'b1;
                    dm           <= 1'b0;
                    eop_done     <= 1'b1;
                    protocol_err <= bit_valid;
                end
                EOP_J: begin
                    state        <= IDLE;
                    dp           <= 1'b1;
                    dm           <= 1'b0;
                    protocol_err <= bit_valid;
                end
                default: begin
                    state <= IDLE;
                    lvl   <= 1'b1;
                    dp    <= 1'b1;
                    dm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrzi_eop_encoder.sv
// Bench for nrzi_eop_encoder: directed scenarios plus randomized packets, every
// cycle compared against a packet-level behavioural model of the line.
module tb_nrzi_eop_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       bstr_in;
    logic [1:0] bstr_in_ready;
    logic       dp, dm, busy, eop_done, protocol_err;
    logic [1:0] pkt_type;
    logic [6:0] bit_count;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: packet activity flag plus a count of EOP bit times left.
    logic       m_lvl, m_active;
    int         m_eop_left;
    logic [1:0] m_pkt;
    int         m_cnt;
    logic       e_dp, e_dm, e_eop, e_err;

    // Observed-event tallies for scenario checks.
    int err_pulses, busy_cycles, se0_cycles, eop_pulses;

    always #5 clk = ~clk;

    nrzi_eop_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .bstr_in      (bstr_in),
        .bstr_in_ready(bstr_in_ready),
        .dp           (dp),
        .dm           (dm),
        .busy         (busy),
        .eop_done     (eop_done),
        .pkt_type     (pkt_type),
        .bit_count    (bit_count),
        .protocol_err (protocol_err)
    );

    function automatic logic [13:0] got_vec();
        return {dp, dm, busy, eop_done, pkt_type, bit_count, protocol_err};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic m_busy;
        m_busy = m_active || (m_eop_left > 0);
        return {e_dp, e_dm, m_busy, e_eop, m_pkt, 7'(m_cnt), e_err};
    endfunction

    task automatic model_step(input logic r, input logic [1:0] tag, input logic b);
        logic valid;
        valid = (tag != 2'b00);
        e_err = 1'b0;
        e_eop = 1'b0;
        if (r) begin
            m_active = 1'b0; m_eop_left = 0; m_lvl = 1'b1;
            m_pkt = 2'b00; m_cnt = 0;
            e_dp = 1'b1; e_dm = 1'b0;
        end else if (m_eop_left > 0) begin
            // SE0, SE0, J: any offered bit is discarded and flagged.
            e_err = valid;
            m_eop_left--;
            if (m_eop_left == 2) begin
                e_dp = 1'b0; e_dm = 1'b0;
            end else begin
                m_lvl = 1'b1; e_dp = 1'b1; e_dm = 1'b0;
                e_eop = (m_eop_left == 1);
            end
        end else if (valid) begin
            if (!m_active) begin
                m_active = 1'b1; m_pkt = tag; m_cnt = 1; m_lvl = 1'b1;
            end else begin
                m_cnt = (m_cnt < 127) ? m_cnt + 1 : 127;
                e_err = (tag != m_pkt);
            end
            if (!b) m_lvl = ~m_lvl;
            e_dp = m_lvl; e_dm = ~m_lvl;
        end else if (m_active) begin
            m_active = 1'b0; m_eop_left = 3;
            e_dp = 1'b0; e_dm = 1'b0;
        end else begin
            e_dp = 1'b1; e_dm = 1'b0;
        end
    endtask

    // Drive one bit time from the falling edge, then observe at the next falling edge.
    task automatic cycle(input logic r, input logic [1:0] tag, input logic b);
        rst = r; bstr_in_ready = tag; bstr_in = b;
        @(posedge clk);
        model_step(r, tag, b);
        @(negedge clk);
        if (protocol_err) err_pulses++;
        if (busy) busy_cycles++;
        if (eop_done) eop_pulses++;
        if (!dp && !dm) se0_cycles++;
    endtask

    task automatic clear_tallies();
        err_pulses = 0; busy_cycles = 0; se0_cycles = 0; eop_pulses = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 1'($urandom));
            tests_run++;
            if (got_vec() !== 14'b1_0_0_0_00_0000000_0) begin
                failed++;
                $display("FAIL reset cyc%0d got %b want %b", i, got_vec(), 14'b10000000000000);
            end
        end
        cycle(1'b0, 2'b00, 1'b0);
        tests_run++;
        if (got_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL reset_idle got %b want %b", got_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_nrzi();
        int bits [4] = '{1, 0, 0, 1};
        clear_tallies();
        for (int i = 0; i < 9; i++) begin
            if (i < 4) cycle(1'b0, 2'b01, 1'(bits[i]));
            else       cycle(1'b0, 2'b00, 1'b0);
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                failed++;
                $display("FAIL basic cyc%0d got %b want %b", i, got_vec(), exp_vec());
            end
        end
        tests_run++;
        if (bit_count !== 7'd4 || pkt_type !== 2'b01 || busy_cycles != 7 || eop_pulses != 1) begin
            failed++;
            $display("FAIL basic_summary cnt=%0d type=%b busy=%0d eop=%0d want 4 01 7 1",
                     bit_count, pkt_type, busy_cycles, eop_pulses);
        end
    endtask

    task automatic test_stuffed_run();
        int bits [8] = '{1, 1, 1, 1, 1, 1, 0, 1};
        logic [1:0] line_seq [8];
        clear_tallies();
        for (int i = 0; i < 12; i++) begin
            if (i < 8) cycle(1'b0, 2'b10, 1'(bits[i]));
            else       cycle(1'b0, 2'b00, 1'b0);
            if (i < 8) line_seq[i] = {dp, dm};
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                failed++;
                $display("FAIL stuffed cyc%0d got %b want %b", i, got_vec(), exp_vec());
            end
        end
        tests_run++;
        if (line_seq[5] !== 2'b10 || line_seq[6] !== 2'b01 || line_seq[7] !== 2'b01 ||
            bit_count !== 7'd8 || err_pulses != 0) begin
            failed++;
            $display("FAIL stuffed_summary j6=%b k7=%b k8=%b cnt=%0d err=%0d want 10 01 01 8 0",
                     line_seq[5], line_seq[6], line_seq[7], bit_count, err_pulses);
        end
    endtask

    task automatic test_tag_change();
        logic err_after4;
        clear_tallies();
        for (int i = 0; i < 8; i++) begin
            if (i < 3)       cycle(1'b0, 2'b01, 1'($urandom));
            else if (i == 3) cycle(1'b0, 2'b11, 1'($urandom));
            else             cycle(1'b0, 2'b00, 1'b0);
            if (i == 3) err_after4 = protocol_err;
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                failed++;
                $display("FAIL tagchg cyc%0d got %b want %b", i, got_vec(), exp_vec());
            end
        end
        tests_run++;
        if (err_after4 !== 1'b1 || err_pulses != 1 || pkt_type !== 2'b01 || bit_count !== 7'd4) begin
            failed++;
            $display("FAIL tagchg_summary err4=%b pulses=%0d type=%b cnt=%0d want 1 1 01 4",
                     err_after4, err_pulses, pkt_type, bit_count);
        end
    endtask

    task automatic test_bits_during_eop();
        // 2 bits, end, SE0_1 quiet, bit during SE0_2, quiet EOP_J, then a new packet.
        logic [1:0] tags [9] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
        int         bits [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
        clear_tallies();
        for (int i = 0; i < 13; i++) begin
            if (i < 9) cycle(1'b0, tags[i], 1'(bits[i]));
            else       cycle(1'b0, 2'b00, 1'b0);
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                failed++;
                $display("FAIL eopbits cyc%0d got %b want %b", i, got_vec(), exp_vec());
            end
        end
        tests_run++;
        if (err_pulses != 1 || se0_cycles != 4 || eop_pulses != 2 || pkt_type !== 2'b11 ||
            bit_count !== 7'd2) begin
            failed++;
            $display("FAIL eopbits_summary err=%0d se0=%0d eop=%0d type=%b cnt=%0d want 1 4 2 11 2",
                     err_pulses, se0_cycles, eop_pulses, pkt_type, bit_count);
        end
    endtask

    task automatic test_saturation();
        int mism = 0;
        clear_tallies();
        for (int i = 0; i < 134; i++) begin
            if (i < 130) cycle(1'b0, 2'b11, 1'(i % 2));
            else         cycle(1'b0, 2'b00, 1'b0);
            if (got_vec() !== exp_vec()) begin
                mism++;
                if (mism == 1) $display("FAIL saturation cyc%0d got %b want %b", i, got_vec(), exp_vec());
            end
            if (i == 129) begin
                tests_run++;
                if (bit_count !== 7'd127) begin
                    failed++;
                    $display("FAIL saturation_count got %0d want 127", bit_count);
                end
            end
        end
        tests_run++;
        if (mism != 0 || err_pulses != 0) begin
            failed++;
            $display("FAIL saturation_trace mismatching_cycles=%0d err=%0d want 0 0", mism, err_pulses);
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_tallies();
        for (int i = 0; i < 12; i++) begin
            if (i < 2)       cycle(1'b0, 2'b01, 1'b0);
            else if (i == 2) cycle(1'b1, 2'b01, 1'b0);
            else if (i < 5)  cycle(1'b0, 2'b00, 1'b0);
            else if (i < 7)  cycle(1'b0, 2'b10, 1'(i == 6));
            else             cycle(1'b0, 2'b00, 1'b0);
            if (i == 2) begin
                tests_run++;
                if ({dp, dm, busy, bit_count} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
                    failed++;
                    $display("FAIL rstmid_abort got dp%b dm%b busy%b cnt%0d want 1 0 0 0",
                             dp, dm, busy, bit_count);
                end
            end
            if (i == 4) begin
                tests_run++;
                if (se0_cycles != 0) begin
                    failed++;
                    $display("FAIL rstmid_no_se0 got %0d se0 cycles want 0", se0_cycles);
                end
            end
            if (i == 5) begin
                tests_run++;
                if ({dp, dm} !== 2'b01) begin
                    failed++;
                    $display("FAIL rstmid_from_j got %b want 01", {dp, dm});
                end
            end
            tests_run++;
            if (got_vec() !== exp_vec()) begin
                failed++;
                $display("FAIL rstmid cyc%0d got %b want %b", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int mism = 0;
        for (int p = 0; p < 60; p++) begin
            int         len = $urandom_range(1, 24);
            logic [1:0] tag = 2'($urandom_range(1, 3));
            for (int i = 0; i < len; i++) begin
                logic [1:0] t = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : tag;
                logic       r = ($urandom_range(0, 299) == 0);
                cycle(r, t, 1'($urandom));
                if (got_vec() !== exp_vec()) mism++;
            end
            for (int g = 0; g < $urandom_range(1, 6); g++) begin
                logic [1:0] t = (g > 0 && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                cycle(1'b0, t, 1'($urandom));
                if (got_vec() !== exp_vec()) mism++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b00, 1'b0);
            if (got_vec() !== exp_vec()) mism++;
        end
        tests_run++;
        if (mism != 0) begin
            failed++;
            $display("FAIL random got %0d mismatching cycles want 0", mism);
        end
    endtask

    initial begin
        rst = 1'b1; bstr_in = 1'b0; bstr_in_ready = 2'b00;
        @(negedge clk);
        test_reset();
        test_basic_nrzi();
        test_stuffed_run();
        test_tag_change();
        test_bits_during_eop();
        test_saturation();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
